// File: rtl/vc_arbiter_demux_pkg.sv
// Shared types and constants for the VC arbiter/demux stage.
package vc_arbiter_demux_pkg;

   typedef enum logic {
      VC_ID_VC0 = 1'b0,
      VC_ID_VC1 = 1'b1
   } vc_id_e;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int DEST_BIT_DEF   = 5;

   // Credit holds at most W-1, so clog2 of the larger weight suffices (min 1 bit).
   function automatic int credit_width(input int w0, input int w1);
      int m;
      m = (w0 > w1) ? w0 : w1;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/vc_arbiter_demux_if.sv
// VC FIFO read side and destination FIFO write side of the arbiter/demux stage.
interface vc_arbiter_demux_if
   import vc_arbiter_demux_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0] vc0_data;
   logic                  vc0_empty;
   logic                  vc0_error;
   logic [DATA_WIDTH-1:0] vc1_data;
   logic                  vc1_empty;
   logic                  vc1_error;
   logic                  d0_full;
   logic                  d0_almost_full;
   logic                  d1_full;
   logic                  d1_almost_full;
   logic                  vc0_pop;
   logic                  vc1_pop;
   logic                  d0_push;
   logic                  d1_push;
   logic [DATA_WIDTH-1:0] d0_data;
   logic [DATA_WIDTH-1:0] d1_data;

   modport master (
      output vc0_data, vc0_empty, vc0_error,
      output vc1_data, vc1_empty, vc1_error,
      output d0_full, d0_almost_full, d1_full, d1_almost_full,
      input  vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data
   );

   modport slave (
      input  vc0_data, vc0_empty, vc0_error,
      input  vc1_data, vc1_empty, vc1_error,
      input  d0_full, d0_almost_full, d1_full, d1_almost_full,
      output vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data
   );
endinterface

// File: rtl/vc_arbiter_demux_wrr.sv
// Two-way weighted round-robin arbiter: an owner keeps the grant while it has
// credit left, otherwise the grant moves to the other requester if it is waiting.
module wrr_arbiter2
   import vc_arbiter_demux_pkg::*;
#(
   parameter int VC0_WEIGHT = 2,
   parameter int VC1_WEIGHT = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic elig0,
   input  logic elig1,
   input  logic allow,
   output logic grant0,
   output logic grant1
);
   localparam int CW = credit_width(VC0_WEIGHT, VC1_WEIGHT);
   localparam logic [CW-1:0] RELOAD0 = CW'(VC0_WEIGHT - 1);
   localparam logic [CW-1:0] RELOAD1 = CW'(VC1_WEIGHT - 1);

   vc_id_e        owner_q, owner_d;
   logic [CW-1:0] credit_q, credit_d;
   logic          owner_elig_s, other_elig_s, credit_avail_s;
   logic          take_owner_s, take_other_s;

   assign owner_elig_s   = (owner_q == VC_ID_VC0) ? elig0 : elig1;
   assign other_elig_s   = (owner_q == VC_ID_VC0) ? elig1 : elig0;
   assign credit_avail_s = (credit_q != {CW{1'b0}});
   assign take_owner_s   = allow & owner_elig_s & (credit_avail_s | ~other_elig_s);
   assign take_other_s   = allow & other_elig_s & ~(owner_elig_s & credit_avail_s);

   // Owner and credit registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q  <= VC_ID_VC0;
         credit_q <= RELOAD0;
      end else begin
         owner_q  <= owner_d;
         credit_q <= credit_d;
      end
   end

   // Next owner/credit: switching loads the newcomer's budget, staying spends or reloads.
   always_comb begin
      owner_d  = owner_q;
      credit_d = credit_q;
      if (take_other_s) begin
         case (owner_q)
            VC_ID_VC0: begin owner_d = VC_ID_VC1; credit_d = RELOAD1; end
            VC_ID_VC1: begin owner_d = VC_ID_VC0; credit_d = RELOAD0; end
            default:   begin owner_d = VC_ID_VC0; credit_d = RELOAD0; end
         endcase
      end else if (take_owner_s) begin
         if (credit_avail_s) begin
            credit_d = credit_q - CW'(1'b1);
         end else begin
            credit_d = (owner_q == VC_ID_VC0) ? RELOAD0 : RELOAD1;
         end
      end else begin
         credit_d = credit_q;
      end
   end

   // Map owner-relative decisions onto the physical grant lines.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (owner_q)
         VC_ID_VC0: begin grant0 = take_owner_s; grant1 = take_other_s; end
         VC_ID_VC1: begin grant0 = take_other_s; grant1 = take_owner_s; end
         default:   begin grant0 = 1'b0;         grant1 = 1'b0;         end
      endcase
   end
endmodule

// File: rtl/vc_arbiter_demux.sv
// Pops the two VC FIFOs by weighted round-robin and steers each word to D0/D1
// by its destination bit, one cycle after the pop (registered FIFO read).
module vc_arbiter_demux
   import vc_arbiter_demux_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEST_BIT   = DEST_BIT_DEF,
   parameter int VC0_WEIGHT = 2,
   parameter int VC1_WEIGHT = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   vc_arbiter_demux_if.slave   bus,
   output logic                idle,
   output logic                err_sticky
);
   logic                  pend_valid_q, pend_valid_d;
   vc_id_e                pend_src_q, pend_src_d;
   logic                  err_q, err_d;
   logic                  space_ok_s, allow_s, grant0_s, grant1_s, pend_live_s;
   logic [DATA_WIDTH-1:0] word_s;

   // Two free slots per D FIFO cover the word in flight plus the one popped now.
   assign space_ok_s = ~(bus.d0_full | bus.d0_almost_full | bus.d1_full | bus.d1_almost_full);
   // Holding pops off during reset keeps words from being read and then discarded.
   assign allow_s     = enable & space_ok_s & ~reset;
   assign pend_live_s = pend_valid_q & ~reset;

   wrr_arbiter2 #(
      .VC0_WEIGHT (VC0_WEIGHT),
      .VC1_WEIGHT (VC1_WEIGHT)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .elig0  (~bus.vc0_empty),
      .elig1  (~bus.vc1_empty),
      .allow  (allow_s),
      .grant0 (grant0_s),
      .grant1 (grant1_s)
   );

   // Pending-word and sticky-error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_valid_q <= 1'b0;
         pend_src_q   <= VC_ID_VC0;
         err_q        <= 1'b0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_src_q   <= pend_src_d;
         err_q        <= err_d;
      end
   end

   // Next pending state follows this cycle's grant.
   always_comb begin
      pend_valid_d = grant0_s | grant1_s;
      pend_src_d   = grant1_s ? VC_ID_VC1 : VC_ID_VC0;
      err_d        = err_q | bus.vc0_error | bus.vc1_error;
   end

   // Demux the word now presented by the FIFO that was popped last cycle.
   always_comb begin
      word_s      = {DATA_WIDTH{1'b0}};
      bus.d0_push = 1'b0;
      bus.d1_push = 1'b0;
      bus.d0_data = {DATA_WIDTH{1'b0}};
      bus.d1_data = {DATA_WIDTH{1'b0}};
      case (pend_src_q)
         VC_ID_VC0: word_s = bus.vc0_data;
         VC_ID_VC1: word_s = bus.vc1_data;
         default:   word_s = {DATA_WIDTH{1'b0}};
      endcase
      if (pend_live_s) begin
         if (word_s[DEST_BIT]) begin
            bus.d1_push = 1'b1;
            bus.d1_data = word_s;
         end else begin
            bus.d0_push = 1'b1;
            bus.d0_data = word_s;
         end
      end else begin
         bus.d0_push = 1'b0;
         bus.d1_push = 1'b0;
      end
   end

   // Pop strobes and status.
   always_comb begin
      bus.vc0_pop = grant0_s;
      bus.vc1_pop = grant1_s;
      idle        = ~pend_live_s & ~grant0_s & ~grant1_s;
      err_sticky  = err_q;
   end
endmodule

// File: tb/tb_vc_arbiter_demux.sv
// Directed bench: a small VC FIFO model feeds the DUT, expected pushes go into a
// scoreboard queue that a forked monitor drains whenever a D push is seen.
module tb_vc_arbiter_demux;
   import vc_arbiter_demux_pkg::*;

   logic clk = 1'b0;
   logic reset, enable, idle, err_sticky;

   vc_arbiter_demux_if bus ();

   vc_arbiter_demux dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .bus        (bus),
      .idle       (idle),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errs   = 0;
   logic [5:0] vc0_q[$];
   logic [5:0] vc1_q[$];
   logic [6:0] exp_q[$];
   logic [1:0] s_pop, s_push;
   logic [5:0] s_d0, s_d1;
   logic       s_idle, s_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Sample outputs mid-cycle, then advance the FIFO model across the edge.
   task automatic tick();
      @(negedge clk);
      s_pop  = {bus.vc1_pop, bus.vc0_pop};
      s_push = {bus.d1_push, bus.d0_push};
      s_d0   = bus.d0_data;
      s_d1   = bus.d1_data;
      s_idle = idle;
      s_err  = err_sticky;
      @(posedge clk);
      #1;
      if (s_pop[0] && vc0_q.size() > 0) bus.vc0_data = vc0_q.pop_front();
      if (s_pop[1] && vc1_q.size() > 0) bus.vc1_data = vc1_q.pop_front();
      bus.vc0_empty = (vc0_q.size() == 0);
      bus.vc1_empty = (vc1_q.size() == 0);
   endtask

   task automatic load(input int vc, input logic [5:0] w);
      if (vc == 0) begin vc0_q.push_back(w); bus.vc0_empty = 1'b0; end
      else         begin vc1_q.push_back(w); bus.vc1_empty = 1'b0; end
   endtask

   task automatic expect_push(input logic [5:0] w);
      exp_q.push_back({w[5], w});
   endtask

   // Pop pattern: '-' none, 'a' VC0, 'b' VC1, one character per cycle.
   task automatic expect_pops(input string name, input string seq);
      logic [1:0] e;
      for (int i = 0; i < seq.len(); i++) begin
         tick();
         e = (seq[i] == "a") ? 2'b01 : (seq[i] == "b") ? 2'b10 : 2'b00;
         check($sformatf("%s[%0d]", name, i), s_pop, e);
      end
   endtask

   task automatic reset_dut(input string name);
      reset = 1'b1;
      tick();
      tick();
      check({name, "_zero"}, {s_pop, s_push, s_d0, s_d1, s_err}, 0);
      check({name, "_idle"}, s_idle, 1);
      reset = 1'b0;
   endtask

   task automatic monitor();
      logic [6:0] e;
      forever begin
         @(negedge clk);
         if (bus.d0_full) check("push_into_full_d0", bus.d0_push, 0);
         if (bus.d1_full) check("push_into_full_d1", bus.d1_push, 0);
         if (bus.d0_push || bus.d1_push) begin
            check("single_push", bus.d0_push & bus.d1_push, 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL unexpected_push: d0=%0h d1=%0h, expected no push", bus.d0_data, bus.d1_data);
            end else begin
               e = exp_q.pop_front();
               check("push_dest", bus.d1_push, e[6]);
               check("push_data", bus.d1_push ? bus.d1_data : bus.d0_data, e[5:0]);
               check("quiet_data", bus.d1_push ? bus.d0_data : bus.d1_data, 0);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b1;
      bus.vc0_data = 6'h00; bus.vc0_empty = 1'b1; bus.vc0_error = 1'b0;
      bus.vc1_data = 6'h00; bus.vc1_empty = 1'b1; bus.vc1_error = 1'b0;
      bus.d0_full = 1'b0; bus.d0_almost_full = 1'b0;
      bus.d1_full = 1'b0; bus.d1_almost_full = 1'b0;
      fork
         monitor();
      join_none

      // A: single VC, back-to-back pops, demux by bit 5.
      reset_dut("A_rst");
      load(0, 6'h01); load(0, 6'h22); load(0, 6'h03);
      expect_push(6'h01); expect_push(6'h22); expect_push(6'h03);
      expect_pops("A_pop", "aaa--");
      check("A_idle", s_idle, 1);

      // B: both VCs busy, weights 2/1 from the reset credit.
      reset_dut("B_rst");
      load(0, 6'h20); load(0, 6'h01); load(0, 6'h22); load(0, 6'h03); load(0, 6'h24); load(0, 6'h05);
      load(1, 6'h30); load(1, 6'h11); load(1, 6'h32); load(1, 6'h13); load(1, 6'h34); load(1, 6'h15);
      expect_push(6'h20); expect_push(6'h30); expect_push(6'h01); expect_push(6'h22);
      expect_push(6'h11); expect_push(6'h03); expect_push(6'h24); expect_push(6'h32);
      expect_push(6'h05); expect_push(6'h13); expect_push(6'h34); expect_push(6'h15);
      expect_pops("B_pop", "abaabaababbb--");

      // C: almost-full stops pops at once, in-flight word still lands.
      reset_dut("C_rst");
      load(0, 6'h21); load(0, 6'h02); load(0, 6'h23); load(0, 6'h04);
      expect_push(6'h21); expect_push(6'h02); expect_push(6'h23); expect_push(6'h04);
      expect_pops("C_pop1", "aa");
      bus.d1_almost_full = 1'b1;
      expect_pops("C_pop2", "-");
      check("C_inflight", s_push, 2'b01);
      bus.d1_full = 1'b1;
      expect_pops("C_pop3", "-");
      bus.d1_full = 1'b0;
      bus.d1_almost_full = 1'b0;
      expect_pops("C_pop4", "aa--");

      // D: enable drops after one pop.
      reset_dut("D_rst");
      load(0, 6'h07); load(0, 6'h08);
      expect_push(6'h07); expect_push(6'h08);
      expect_pops("D_pop1", "a");
      enable = 1'b0;
      expect_pops("D_pop2", "-");
      check("D_inflight", s_push, 2'b01);
      expect_pops("D_pop3", "--");
      check("D_idle", s_idle, 1);
      enable = 1'b1;
      expect_pops("D_pop4", "a-");

      // E: reset right after a VC1 pop drops the word and restores owner VC0.
      reset_dut("E_rst");
      load(1, 6'h2A);
      expect_pops("E_pop", "b");
      reset = 1'b1;
      tick();
      check("E_nopush", s_push, 0);
      tick();
      check("E_zero", {s_pop, s_push, s_d0, s_d1, s_err}, 0);
      check("E_idle", s_idle, 1);
      reset = 1'b0;
      load(0, 6'h09); load(0, 6'h2B); load(0, 6'h0C);
      load(1, 6'h1D); load(1, 6'h3E); load(1, 6'h0F);
      expect_push(6'h09); expect_push(6'h1D); expect_push(6'h2B);
      expect_push(6'h0C); expect_push(6'h3E); expect_push(6'h0F);
      expect_pops("E_owner", "abaabb--");

      // F: one-cycle error pulse is held until reset.
      bus.vc1_error = 1'b1;
      tick();
      check("F_before", s_err, 0);
      bus.vc1_error = 1'b0;
      tick();
      check("F_set", s_err, 1);
      tick();
      tick();
      check("F_hold", s_err, 1);
      reset_dut("F_rst");

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      check("drain", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end
endmodule
